// File: rtl/intersection_controller.sv
// Two-way intersection scheduler with all-red clearance between conflicting greens.
// Optional pedestrian WALK phase is compiled in when INTERSECTION_PED_EN is defined.
module intersection_controller #(
  parameter int unsigned GREEN_CYCLES   = 50,
  parameter int unsigned YELLOW_CYCLES  = 10,
  parameter int unsigned ALL_RED_CYCLES = 5,
  parameter int unsigned WALK_CYCLES    = 30
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ped_req,
  output logic ped_ack,
  output logic ns_red,
  output logic ns_yellow,
  output logic ns_green,
  output logic ew_red,
  output logic ew_yellow,
  output logic ew_green,
  output logic ped_walk
);

  localparam int unsigned MAX_GY  = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
  localparam int unsigned MAX_AW  = (ALL_RED_CYCLES > WALK_CYCLES) ? ALL_RED_CYCLES : WALK_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_GY > MAX_AW) ? MAX_GY : MAX_AW;
  localparam int unsigned TW      = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

  typedef enum logic [2:0] {
    S_ALL_RED   = 3'd0,
    S_NS_GREEN  = 3'd1,
    S_NS_YELLOW = 3'd2,
    S_EW_GREEN  = 3'd3,
    S_EW_YELLOW = 3'd4,
    S_WALK      = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic            next_ew, next_ew_nxt;
  logic            ped_pending;
  logic [TW-1:0]   last_cnt;
  logic            done;

  // Terminal count of the current phase.
  always_comb begin
    last_cnt = '0;
    case (state)
      S_ALL_RED:   last_cnt = TW'(ALL_RED_CYCLES - 1);
      S_NS_GREEN,
      S_EW_GREEN:  last_cnt = TW'(GREEN_CYCLES - 1);
      S_NS_YELLOW,
      S_EW_YELLOW: last_cnt = TW'(YELLOW_CYCLES - 1);
      S_WALK:      last_cnt = TW'(WALK_CYCLES - 1);
      default:     last_cnt = '0;
    endcase
  end

  assign done = (timer == last_cnt);

  // State register, phase timer and direction selector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_ALL_RED;
      timer   <= '0;
      next_ew <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      next_ew <= next_ew_nxt;
    end
  end

  // Next-state logic; the timer clears on every transition.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer + TW'(1);
    next_ew_nxt = next_ew;
    case (state)
      S_ALL_RED: begin
        if (done) begin
          timer_nxt = '0;
`ifdef INTERSECTION_PED_EN
          if (ped_pending)  state_nxt = S_WALK;
          else if (next_ew) state_nxt = S_EW_GREEN;
          else              state_nxt = S_NS_GREEN;
`else
          state_nxt = next_ew ? S_EW_GREEN : S_NS_GREEN;
`endif
        end
      end
      S_NS_GREEN: begin
        if (done) begin
          timer_nxt = '0;
          state_nxt = S_NS_YELLOW;
        end
      end
      S_NS_YELLOW: begin
        if (done) begin
          timer_nxt   = '0;
          state_nxt   = S_ALL_RED;
          next_ew_nxt = 1'b1;
        end
      end
      S_EW_GREEN: begin
        if (done) begin
          timer_nxt = '0;
          state_nxt = S_EW_YELLOW;
        end
      end
      S_EW_YELLOW: begin
        if (done) begin
          timer_nxt   = '0;
          state_nxt   = S_ALL_RED;
          next_ew_nxt = 1'b0;
        end
      end
`ifdef INTERSECTION_PED_EN
      S_WALK: begin
        if (done) begin
          timer_nxt = '0;
          state_nxt = next_ew ? S_EW_GREEN : S_NS_GREEN;
        end
      end
`endif
      default: begin
        timer_nxt = '0;
        state_nxt = S_ALL_RED;
      end
    endcase
  end

`ifdef INTERSECTION_PED_EN
  // Pedestrian request latch; clearing on WALK entry takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ped_pending <= 1'b0;
    end else if (state_nxt == S_WALK && state != S_WALK) begin
      ped_pending <= 1'b0;
    end else if (ped_req) begin
      ped_pending <= 1'b1;
    end
  end

  assign ped_walk = (state == S_WALK);
  assign ped_ack  = (state == S_WALK) && (timer == '0);
`else
  logic unused_ped;
  assign unused_ped  = ped_req;
  assign ped_pending = 1'b0;
  assign ped_walk    = 1'b0;
  assign ped_ack     = 1'b0;
`endif

  // Lamp decode from the registered state.
  assign ns_green  = (state == S_NS_GREEN);
  assign ns_yellow = (state == S_NS_YELLOW);
  assign ns_red    = !(ns_green || ns_yellow);
  assign ew_green  = (state == S_EW_GREEN);
  assign ew_yellow = (state == S_EW_YELLOW);
  assign ew_red    = !(ew_green || ew_yellow);

endmodule
